// File: rtl/timer_counter_pkg.sv
// Shared constants and helpers for the 8051 Timer/Counter slice: SFR op encoding,
// TMOD field layout and mode codes.
package timer_counter_pkg;

    localparam int SFR_OP_LEN = 16;

    // One-hot SFR write-op masks for the timer byte registers
    localparam logic [SFR_OP_LEN-1:0] OP_TH0_WR_BYTE = 16'h0010;
    localparam logic [SFR_OP_LEN-1:0] OP_TL0_WR_BYTE = 16'h0020;
    localparam logic [SFR_OP_LEN-1:0] OP_TH1_WR_BYTE = 16'h0040;
    localparam logic [SFR_OP_LEN-1:0] OP_TL1_WR_BYTE = 16'h0080;

    // Bit positions inside a TMOD nibble
    localparam int TMOD_GATE = 3;
    localparam int TMOD_CT   = 2;
    localparam int TMOD_M1   = 1;
    localparam int TMOD_M0   = 0;

    typedef enum logic [1:0] {
        TMR_MODE0 = 2'd0,
        TMR_MODE1 = 2'd1,
        TMR_MODE2 = 2'd2,
        TMR_MODE3 = 2'd3
    } tmr_mode_e;

    typedef struct packed {
        logic      gate;
        logic      ct;
        tmr_mode_e mode;
    } tmod_t;

    function automatic tmod_t decode_tmod(input logic [3:0] nibble);
        tmod_t t;
        t.gate = nibble[TMOD_GATE];
        t.ct   = nibble[TMOD_CT];
        t.mode = tmr_mode_e'({nibble[TMOD_M1], nibble[TMOD_M0]});
        return t;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Shared SFR op bus as seen by one SFR register: write data plus op bit mask.
interface timer_counter_if;
    import timer_counter_pkg::*;

    logic [7:0]            sfr_byte;
    logic [SFR_OP_LEN-1:0] sfr_op;

    modport master (output sfr_byte, output sfr_op);
    modport slave  (input  sfr_byte, input  sfr_op);

endinterface

// File: rtl/tmr_pin_edge.sv
// Synchronises an asynchronous Tx pin and reports a falling edge seen between two
// consecutive machine-cycle samples; pulses narrower than a tick are never seen.
module tmr_pin_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    input  logic i_tick,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sample_reg;
    logic                   pin_synced;

    assign pin_synced = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_reg   <= '1;
            sample_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_pin};
            if (i_tick) begin
                sample_reg <= pin_synced;
            end
        end
    end

    // Valid only on the tick itself: previous sample high, current sample low
    assign o_fall = i_tick & sample_reg & ~pin_synced;

endmodule

// File: rtl/timer_counter.sv
// One 8051 Timer/Counter (T0 or T1): THx/TLx, TMOD modes 0-3, GATE/C-T qualification
// and single-clock overflow pulses towards TCON.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int                    TIMER_ID = 0,
    parameter logic [SFR_OP_LEN-1:0] OP_TH_WR = OP_TH0_WR_BYTE,
    parameter logic [SFR_OP_LEN-1:0] OP_TL_WR = OP_TL0_WR_BYTE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    timer_counter_if.slave        sfr,
    input  logic [3:0]            i_tmod,
    input  logic                  i_tr,
    input  logic                  i_tr_hi,
    input  logic                  i_int_n,
    input  logic                  i_t_pin,
    input  logic                  i_tick,
    output logic [7:0]            o_th,
    output logic [7:0]            o_tl,
    output logic                  o_ovf,
    output logic                  o_ovf_hi
);

    tmod_t       tmod;
    logic        run;
    logic        pin_fall;
    logic        cnt;
    logic        hi_cnt;
    logic        wr_th;
    logic        wr_tl;

    logic [7:0]  th_reg,     th_next;
    logic [7:0]  tl_reg,     tl_next;
    logic        ovf_reg,    ovf_next;
    logic        ovf_hi_reg, ovf_hi_next;

    logic [12:0] sum13;
    logic [15:0] sum16;
    logic [7:0]  tl_inc;
    logic [7:0]  th_inc;

    tmr_pin_edge #(
        .SYNC_STAGES (2)
    ) u_pin_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pin  (i_t_pin),
        .i_tick (i_tick),
        .o_fall (pin_fall)
    );

    assign tmod   = decode_tmod(i_tmod);
    assign run    = i_tr & (~tmod.gate | i_int_n);
    assign cnt    = i_tick & run & (~tmod.ct | pin_fall);
    // The split high half of Timer0 is a pure timer run by TR1, with no gating
    assign hi_cnt = (TIMER_ID == 0) && i_tick && i_tr_hi;

    assign wr_th  = |(sfr.sfr_op & OP_TH_WR);
    assign wr_tl  = |(sfr.sfr_op & OP_TL_WR);

    assign sum13  = {th_reg, tl_reg[4:0]} + 13'd1;
    assign sum16  = {th_reg, tl_reg} + 16'd1;
    assign tl_inc = tl_reg + 8'd1;
    assign th_inc = th_reg + 8'd1;

    always_comb begin
        th_next     = th_reg;
        tl_next     = tl_reg;
        ovf_next    = 1'b0;
        ovf_hi_next = 1'b0;

        // A CPU write to either byte freezes the whole timer for that clock
        if (wr_th || wr_tl) begin
            if (wr_th) th_next = sfr.sfr_byte;
            if (wr_tl) tl_next = sfr.sfr_byte;
        end else begin
            unique case (tmod.mode)
                TMR_MODE0: begin
                    if (cnt) begin
                        th_next      = sum13[12:5];
                        tl_next[4:0] = sum13[4:0];
                        ovf_next     = &{th_reg, tl_reg[4:0]};
                    end
                end
                TMR_MODE1: begin
                    if (cnt) begin
                        {th_next, tl_next} = sum16;
                        ovf_next           = &{th_reg, tl_reg};
                    end
                end
                TMR_MODE2: begin
                    if (cnt) begin
                        if (&tl_reg) begin
                            tl_next  = th_reg;
                            ovf_next = 1'b1;
                        end else begin
                            tl_next = tl_inc;
                        end
                    end
                end
                TMR_MODE3: begin
                    if (TIMER_ID == 0) begin
                        if (cnt) begin
                            tl_next  = tl_inc;
                            ovf_next = &tl_reg;
                        end
                        if (hi_cnt) begin
                            th_next     = th_inc;
                            ovf_hi_next = &th_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            th_reg     <= 8'h00;
            tl_reg     <= 8'h00;
            ovf_reg    <= 1'b0;
            ovf_hi_reg <= 1'b0;
        end else begin
            th_reg     <= th_next;
            tl_reg     <= tl_next;
            ovf_reg    <= ovf_next;
            ovf_hi_reg <= ovf_hi_next;
        end
    end

    assign o_th     = th_reg;
    assign o_tl     = tl_reg;
    assign o_ovf    = ovf_reg;
    assign o_ovf_hi = ovf_hi_reg;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: Timer0 and Timer1 instances, expectations queued
// as stimulus is driven and popped when the outputs settle.
module tb_timer_counter;
    import timer_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       int_n;
    logic       t_pin;
    logic       tr0, tr1, tr_hi;
    logic [3:0] tmod0, tmod1;

    logic [7:0] th0, tl0, th1, tl1;
    logic       ovf0, ovf_hi0, ovf1, ovf_hi1;

    timer_counter_if bus0 ();
    timer_counter_if bus1 ();

    always #5 clk = ~clk;

    timer_counter #(
        .TIMER_ID (0),
        .OP_TH_WR (OP_TH0_WR_BYTE),
        .OP_TL_WR (OP_TL0_WR_BYTE)
    ) dut0 (
        .i_clk    (clk),
        .i_rst    (rst),
        .sfr      (bus0.slave),
        .i_tmod   (tmod0),
        .i_tr     (tr0),
        .i_tr_hi  (tr_hi),
        .i_int_n  (int_n),
        .i_t_pin  (t_pin),
        .i_tick   (tick),
        .o_th     (th0),
        .o_tl     (tl0),
        .o_ovf    (ovf0),
        .o_ovf_hi (ovf_hi0)
    );

    timer_counter #(
        .TIMER_ID (1),
        .OP_TH_WR (OP_TH1_WR_BYTE),
        .OP_TL_WR (OP_TL1_WR_BYTE)
    ) dut1 (
        .i_clk    (clk),
        .i_rst    (rst),
        .sfr      (bus1.slave),
        .i_tmod   (tmod1),
        .i_tr     (tr1),
        .i_tr_hi  (tr_hi),
        .i_int_n  (int_n),
        .i_t_pin  (t_pin),
        .i_tick   (tick),
        .o_th     (th1),
        .o_tl     (tl1),
        .o_ovf    (ovf1),
        .o_ovf_hi (ovf_hi1)
    );

    typedef struct packed {
        logic       dut;
        logic [7:0] th;
        logic [7:0] tl;
        logic       ovf;
        logic       ovf_hi;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic expect_out(input string tag, input logic dut, input logic [7:0] th,
                              input logic [7:0] tl, input logic ovf, input logic ovf_hi);
        exp_t e;
        e.dut = dut; e.th = th; e.tl = tl; e.ovf = ovf; e.ovf_hi = ovf_hi;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_field(input string tag, input string field,
                               input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %h expected %h", tag, field, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t  e;
        string tag;
        logic [7:0] o_th, o_tl;
        logic       o_ovf, o_ovf_hi;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e   = sb_q.pop_front();
            tag = tag_q.pop_front();
            if (e.dut == 1'b0) begin
                o_th = th0; o_tl = tl0; o_ovf = ovf0; o_ovf_hi = ovf_hi0;
            end else begin
                o_th = th1; o_tl = tl1; o_ovf = ovf1; o_ovf_hi = ovf_hi1;
            end
            check_field(tag, "th",     o_th,            e.th);
            check_field(tag, "tl",     o_tl,            e.tl);
            check_field(tag, "ovf",    {7'd0, o_ovf},    {7'd0, e.ovf});
            check_field(tag, "ovf_hi", {7'd0, o_ovf_hi}, {7'd0, e.ovf_hi});
            $display("check %s dut%0d: th=%h tl=%h ovf=%b ovf_hi=%b", tag, e.dut,
                     o_th, o_tl, o_ovf, o_ovf_hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_once();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_once();
            idle(10);
        end
    endtask

    task automatic sfr_write(input logic dut, input logic th_en, input logic tl_en,
                             input logic [7:0] b);
        logic [SFR_OP_LEN-1:0] op;
        @(negedge clk);
        if (dut == 1'b0) begin
            op = (th_en ? OP_TH0_WR_BYTE : '0) | (tl_en ? OP_TL0_WR_BYTE : '0);
            bus0.sfr_op = op; bus0.sfr_byte = b;
        end else begin
            op = (th_en ? OP_TH1_WR_BYTE : '0) | (tl_en ? OP_TL1_WR_BYTE : '0);
            bus1.sfr_op = op; bus1.sfr_byte = b;
        end
        @(negedge clk);
        bus0.sfr_op = '0;
        bus1.sfr_op = '0;
    endtask

    task automatic pin_edge();
        t_pin = 1'b1;
        idle(4);
        tick_once();
        idle(4);
        t_pin = 1'b0;
        idle(4);
        tick_once();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; int_n = 1'b1; t_pin = 1'b1;
        tr0 = 1'b0; tr1 = 1'b0; tr_hi = 1'b0; tmod0 = 4'h0; tmod1 = 4'h0;
        bus0.sfr_op = '0; bus0.sfr_byte = 8'h00;
        bus1.sfr_op = '0; bus1.sfr_byte = 8'h00;
        idle(3);
        rst = 1'b0;
        expect_out("reset0", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0); compare_out();
        expect_out("reset1", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0); compare_out();

        // Mode 1 timer: FFFE -> FFFF -> 0000 with overflow
        tmod0 = 4'b0001; tr0 = 1'b1;
        sfr_write(1'b0, 1'b1, 1'b0, 8'hFF);
        sfr_write(1'b0, 1'b0, 1'b1, 8'hFE);
        expect_out("m1_t1", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0); tick_once(); compare_out();
        idle(10);
        expect_out("m1_t2", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0); tick_once(); compare_out();
        expect_out("m1_pulse", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0); idle(1); compare_out();

        // Mode 2 auto-reload from TH
        tmod0 = 4'b0010;
        sfr_write(1'b0, 1'b1, 1'b0, 8'h9C);
        sfr_write(1'b0, 1'b0, 1'b1, 8'hFF);
        expect_out("m2_reload", 1'b0, 8'h9C, 8'h9C, 1'b1, 1'b0); tick_once(); compare_out();
        idle(10);
        ticks(99);
        expect_out("m2_ff", 1'b0, 8'h9C, 8'hFF, 1'b0, 1'b0); compare_out();
        expect_out("m2_reload2", 1'b0, 8'h9C, 8'h9C, 1'b1, 1'b0); tick_once(); compare_out();

        // Mode 0: 13-bit, TL[7:5] untouched
        tmod0 = 4'b0000;
        sfr_write(1'b0, 1'b1, 1'b0, 8'h12);
        sfr_write(1'b0, 1'b0, 1'b1, 8'h1F);
        expect_out("m0_carry", 1'b0, 8'h13, 8'h00, 1'b0, 1'b0); tick_once(); compare_out();
        sfr_write(1'b0, 1'b1, 1'b0, 8'hFF);
        sfr_write(1'b0, 1'b0, 1'b1, 8'hBF);
        expect_out("m0_ovf", 1'b0, 8'h00, 8'hA0, 1'b1, 1'b0); tick_once(); compare_out();

        // Counter with GATE: blocked while INT is low
        tmod0 = 4'b1101; int_n = 1'b0;
        sfr_write(1'b0, 1'b1, 1'b1, 8'h00);
        repeat (3) pin_edge();
        expect_out("gate_blocked", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0); compare_out();
        int_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            expect_out($sformatf("cnt_edge%0d", i), 1'b0, 8'h00, 8'(i), 1'b0, 1'b0);
            pin_edge();
            compare_out();
        end
        // Low glitch between two ticks must be missed
        t_pin = 1'b1; idle(4); tick_once(); idle(2);
        t_pin = 1'b0; idle(1); t_pin = 1'b1; idle(4);
        expect_out("glitch", 1'b0, 8'h00, 8'h03, 1'b0, 1'b0); tick_once(); compare_out();

        // Mode 3 on Timer0: split TH run by TR1
        tmod0 = 4'b0011; tr0 = 1'b0; tr_hi = 1'b1;
        sfr_write(1'b0, 1'b1, 1'b0, 8'hFF);
        sfr_write(1'b0, 1'b0, 1'b1, 8'h42);
        expect_out("m3_hi", 1'b0, 8'h00, 8'h42, 1'b0, 1'b1); tick_once(); compare_out();
        expect_out("m3_hi_pulse", 1'b0, 8'h00, 8'h42, 1'b0, 1'b0); idle(1); compare_out();
        tr0 = 1'b1; tr_hi = 1'b0;
        expect_out("m3_tl", 1'b0, 8'h00, 8'h43, 1'b0, 1'b0); tick_once(); compare_out();
        // Write on the tick freezes split TH too
        tr0 = 1'b0; tr_hi = 1'b1;
        @(negedge clk);
        bus0.sfr_op = OP_TL0_WR_BYTE; bus0.sfr_byte = 8'h10; tick = 1'b1;
        @(negedge clk);
        bus0.sfr_op = '0; tick = 1'b0;
        expect_out("m3_wr_col", 1'b0, 8'h00, 8'h10, 1'b0, 1'b0); compare_out();
        tr_hi = 1'b0;

        // Timer1: mode 1 counts, mode 3 holds
        tmod1 = 4'b0001; tr1 = 1'b1;
        sfr_write(1'b1, 1'b1, 1'b0, 8'h00);
        sfr_write(1'b1, 1'b0, 1'b1, 8'hFF);
        expect_out("t1_m1", 1'b1, 8'h01, 8'h00, 1'b0, 1'b0); tick_once(); compare_out();
        tmod1 = 4'b0011; tr_hi = 1'b1;
        sfr_write(1'b1, 1'b1, 1'b0, 8'hFF);
        sfr_write(1'b1, 1'b0, 1'b1, 8'hFF);
        expect_out("t1_m3_hold", 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0); tick_once(); compare_out();
        idle(1);
        expect_out("t1_m3_hold2", 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0); compare_out();
        tr_hi = 1'b0;

        // Collision in mode 1: write wins over overflow
        tmod0 = 4'b0001; tr0 = 1'b1;
        sfr_write(1'b0, 1'b1, 1'b1, 8'hFF);
        @(negedge clk);
        bus0.sfr_op = OP_TL0_WR_BYTE; bus0.sfr_byte = 8'h55; tick = 1'b1;
        @(negedge clk);
        bus0.sfr_op = '0; tick = 1'b0;
        expect_out("collision", 1'b0, 8'hFF, 8'h55, 1'b0, 1'b0); compare_out();
        idle(1);
        expect_out("collision_nopulse", 1'b0, 8'hFF, 8'h55, 1'b0, 1'b0); compare_out();

        // Reset on the overflowing tick discards everything
        sfr_write(1'b0, 1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        tick = 1'b1; rst = 1'b1;
        @(negedge clk);
        tick = 1'b0; rst = 1'b0;
        expect_out("rst_mid0", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0); compare_out();
        expect_out("rst_mid1", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0); compare_out();
        expect_out("rst_after", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0); idle(1); compare_out();

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
